// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM access controller.
// Holds the FSM state encoding, bus widths and default strobe lengths.
package sram_ctrl_pkg;

    localparam int ADDR_W        = 12;
    localparam int DATA_W        = 8;
    localparam int CNT_W         = 4;
    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_CYCLES_DEF = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SETUP = 4'd1,
        ST_WRITE = 4'd2,
        ST_SENSE = 4'd3,
        ST_RESP  = 4'd4
    } state_e;

    // The counter counts down to zero, so an N-cycle strobe loads N-1.
    function automatic logic [CNT_W-1:0] strobe_load(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/sram_access_ctrl_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer names the requester that
// wins the next tie and flips away from whoever was just granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;

    // Grant decode: single requester wins outright, a tie goes to the pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer register: after a grant, favour the other requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Two-requester SRAM access controller: arbitrates, sequences address setup,
// write/sense strobes and a response pulse, all outputs registered.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rsp,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rsp,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_write_en,
    output logic              sram_sense_en,
    input  logic [DATA_W-1:0] sram_dout
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  din_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               wen_q, sen_q, busy_q;
    logic               rdy0_q, rdy1_q, rsp0_q, rsp1_q;
    logic [1:0]         req_s;
    logic [1:0]         grant_s;
    logic               accept_s;

    assign req_s    = {req1_valid, req0_valid};
    assign accept_s = (state_q == ST_IDLE) && (req_s != 2'b00);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req_s),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // Next-state and strobe counter; the counter reloads on every strobe entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (we_q) begin
                    state_d = ST_WRITE;
                    cnt_d   = strobe_load(WR_CYCLES);
                end else begin
                    state_d = ST_SENSE;
                    cnt_d   = strobe_load(RD_CYCLES);
                end
            end
            ST_WRITE, ST_SENSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; strobes and busy follow the next state so they
    // line up with the state they belong to without a combinational path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            wen_q   <= 1'b0;
            sen_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            if (accept_s) begin
                sel_q  <= grant_s[1];
                we_q   <= grant_s[1] ? req1_we    : req0_we;
                addr_q <= grant_s[1] ? req1_addr  : req0_addr;
                din_q  <= grant_s[1] ? req1_wdata : req0_wdata;
            end
            if ((state_q == ST_SENSE) && (cnt_q == 4'd0)) begin
                rdata_q <= sram_dout;
            end
            wen_q  <= (state_d == ST_WRITE);
            sen_q  <= (state_d == ST_SENSE);
            busy_q <= (state_d != ST_IDLE);
            rdy0_q <= accept_s && grant_s[0];
            rdy1_q <= accept_s && grant_s[1];
            rsp0_q <= (state_q == ST_RESP) && !sel_q;
            rsp1_q <= (state_q == ST_RESP) &&  sel_q;
        end
    end

    assign req0_ready    = rdy0_q;
    assign req1_ready    = rdy1_q;
    assign req0_rsp      = rsp0_q;
    assign req1_rsp      = rsp1_q;
    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign sram_addr     = addr_q;
    assign sram_din      = din_q;
    assign sram_write_en = wen_q;
    assign sram_sense_en = sen_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: default instance u0 and swept instance u1
// (RD_CYCLES=1, WR_CYCLES=5), a transaction-timeline model and directed tests.
module tb_sram_access_ctrl;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic        r0v[2], r0we[2], r1v[2], r1we[2];
    logic [11:0] r0a[2], r1a[2], saddr[2];
    logic [7:0]  r0d[2], r1d[2], rdata[2], sdin[2], sdout[2];
    logic        rdy0[2], rdy1[2], rsp0[2], rsp1[2], busy[2], wen[2], sen[2];
    logic [7:0]  mem_s[2][4096];
    logic [7:0]  mem_m[2][4096];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sram_access_ctrl u0 (
        .clk(clk), .resetn(resetn),
        .req0_valid(r0v[0]), .req0_we(r0we[0]), .req0_addr(r0a[0]), .req0_wdata(r0d[0]),
        .req0_ready(rdy0[0]), .req0_rsp(rsp0[0]),
        .req1_valid(r1v[0]), .req1_we(r1we[0]), .req1_addr(r1a[0]), .req1_wdata(r1d[0]),
        .req1_ready(rdy1[0]), .req1_rsp(rsp1[0]),
        .rdata(rdata[0]), .busy(busy[0]), .sram_addr(saddr[0]), .sram_din(sdin[0]),
        .sram_write_en(wen[0]), .sram_sense_en(sen[0]), .sram_dout(sdout[0])
    );

    sram_access_ctrl #(.RD_CYCLES(1), .WR_CYCLES(5)) u1 (
        .clk(clk), .resetn(resetn),
        .req0_valid(r0v[1]), .req0_we(r0we[1]), .req0_addr(r0a[1]), .req0_wdata(r0d[1]),
        .req0_ready(rdy0[1]), .req0_rsp(rsp0[1]),
        .req1_valid(r1v[1]), .req1_we(r1we[1]), .req1_addr(r1a[1]), .req1_wdata(r1d[1]),
        .req1_ready(rdy1[1]), .req1_rsp(rsp1[1]),
        .rdata(rdata[1]), .busy(busy[1]), .sram_addr(saddr[1]), .sram_din(sdin[1]),
        .sram_write_en(wen[1]), .sram_sense_en(sen[1]), .sram_dout(sdout[1])
    );

    // Behavioural SRAM arrays: asynchronous read, write on the rising edge.
    assign sdout[0] = mem_s[0][saddr[0]];
    assign sdout[1] = mem_s[1][saddr[1]];
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) if (wen[k]) mem_s[k][saddr[k]] = sdin[k];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-timeline model: an op accepted at edge t with strobe length n
    // has ready at t, strobe over edges t+1..t+n, rsp at t+2+n, next accept t+3+n.
    logic        m_ok = 1'b0;
    logic        m_act[2], m_ptr[2], m_sel[2], m_we[2];
    int          m_t[2], m_n[2];
    logic [11:0] m_addr[2];
    logic [7:0]  m_din[2], e_rdata[2];
    logic        e_rdy0[2], e_rdy1[2], e_rsp0[2], e_rsp1[2], e_busy[2], e_wen[2], e_sen[2];

    initial forever begin
        int t, n;
        logic sel;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 1'b0; m_ptr[k] = 1'b0; m_sel[k] = 1'b0; m_we[k] = 1'b0;
                m_addr[k] = 12'h000; m_din[k] = 8'h00; e_rdata[k] = 8'h00;
                e_rdy0[k] = 1'b0; e_rdy1[k] = 1'b0; e_rsp0[k] = 1'b0; e_rsp1[k] = 1'b0;
                e_busy[k] = 1'b0; e_wen[k] = 1'b0; e_sen[k] = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (!m_act[k] && (r0v[k] || r1v[k])) begin
                    sel = (r0v[k] && r1v[k]) ? m_ptr[k] : r1v[k];
                    m_ptr[k]  = !sel;
                    m_sel[k]  = sel;
                    m_act[k]  = 1'b1;
                    m_t[k]    = cyc;
                    m_we[k]   = sel ? r1we[k] : r0we[k];
                    m_addr[k] = sel ? r1a[k] : r0a[k];
                    m_din[k]  = sel ? r1d[k] : r0d[k];
                    m_n[k]    = m_we[k] ? ((k == 1) ? 5 : 2) : ((k == 1) ? 1 : 2);
                end
                e_rdy0[k] = 1'b0; e_rdy1[k] = 1'b0; e_rsp0[k] = 1'b0; e_rsp1[k] = 1'b0;
                e_busy[k] = 1'b0; e_wen[k] = 1'b0; e_sen[k] = 1'b0;
                if (m_act[k]) begin
                    t = m_t[k];
                    n = m_n[k];
                    e_rdy0[k] = (cyc == t) && !m_sel[k];
                    e_rdy1[k] = (cyc == t) &&  m_sel[k];
                    e_busy[k] = (cyc <= t + 1 + n);
                    e_wen[k]  =  m_we[k] && (cyc >= t + 1) && (cyc <= t + n);
                    e_sen[k]  = !m_we[k] && (cyc >= t + 1) && (cyc <= t + n);
                    e_rsp0[k] = (cyc == t + 2 + n) && !m_sel[k];
                    e_rsp1[k] = (cyc == t + 2 + n) &&  m_sel[k];
                    if (!m_we[k] && (cyc == t + 1 + n)) e_rdata[k] = mem_m[k][m_addr[k]];
                    if (m_we[k] && (cyc == t + 2)) mem_m[k][m_addr[k]] = m_din[k];
                    if (cyc == t + 2 + n) m_act[k] = 1'b0;
                end
            end
        end
        m_ok = 1'b1;
    end

    // Per-cycle compare of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.req0_ready", k), rdy0[k], e_rdy0[k]);
                chk($sformatf("u%0d.req1_ready", k), rdy1[k], e_rdy1[k]);
                chk($sformatf("u%0d.req0_rsp", k), rsp0[k], e_rsp0[k]);
                chk($sformatf("u%0d.req1_rsp", k), rsp1[k], e_rsp1[k]);
                chk($sformatf("u%0d.busy", k), busy[k], e_busy[k]);
                chk($sformatf("u%0d.write_en", k), wen[k], e_wen[k]);
                chk($sformatf("u%0d.sense_en", k), sen[k], e_sen[k]);
                chk($sformatf("u%0d.rdata", k), rdata[k], e_rdata[k]);
                chk($sformatf("u%0d.sram_addr", k), saddr[k], m_addr[k]);
                chk($sformatf("u%0d.sram_din", k), sdin[k], m_din[k]);
                chk($sformatf("u%0d.strobe_overlap", k), wen[k] & sen[k], 1'b0);
            end
        end
    end

    task automatic set_req(input int k, input int r, input logic v, input logic we,
                           input logic [11:0] a, input logic [7:0] d);
        if (r == 1) begin
            r1v[k] = v; r1we[k] = we; r1a[k] = a; r1d[k] = d;
        end else begin
            r0v[k] = v; r0we[k] = we; r0a[k] = a; r0d[k] = d;
        end
    endtask

    function automatic logic get_rdy(input int k, input int r);
        return (r == 1) ? rdy1[k] : rdy0[k];
    endfunction

    function automatic logic get_rsp(input int k, input int r);
        return (r == 1) ? rsp1[k] : rsp0[k];
    endfunction

    task automatic do_req(input int k, input int r, input logic we, input logic [11:0] a,
                          input logic [7:0] d, output int t_rdy, output int t_rsp, output int nstb);
        logic got;
        @(negedge clk);
        set_req(k, r, 1'b1, we, a, d);
        got = 1'b0; t_rdy = -1; t_rsp = -1; nstb = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (get_rdy(k, r)) begin got = 1'b1; t_rdy = cyc; end
        end
        set_req(k, r, 1'b0, 1'b0, 12'h000, 8'h00);
        chk("ready_seen", got, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (we ? wen[k] : sen[k]) nstb++;
            if (get_rsp(k, r)) begin got = 1'b1; t_rsp = cyc; end
        end
        chk("rsp_seen", got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tr, tp, ns, gcnt, prev;
        logic [5:0] gseq;
        logic got;
        resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b0, 1'b0, 12'h000, 8'h00);
            set_req(k, 1, 1'b0, 1'b0, 12'h000, 8'h00);
            for (int i = 0; i < 4096; i++) begin
                mem_s[k][i] = i[7:0] ^ 8'h5A;
                mem_m[k][i] = i[7:0] ^ 8'h5A;
            end
            mem_s[k][12'h0A5] = 8'h3C;
            mem_m[k][12'h0A5] = 8'h3C;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_rdata", rdata[0], 8'h00);
        chk("rst_addr", saddr[0], 12'h000);
        chk("rst_ready", rdy0[0] | rdy1[0] | rdy0[1] | rdy1[1], 1'b0);
        resetn = 1'b1;

        // Single read, default timing.
        do_req(0, 0, 1'b0, 12'h0A5, 8'h00, tr, tp, ns);
        chk("rd_latency", tp - tr, 4);
        chk("rd_sense_cycles", ns, 2);
        chk("rd_data", rdata[0], 8'h3C);

        // Single write from requester 1, then read it back.
        do_req(0, 1, 1'b1, 12'hFFF, 8'h81, tr, tp, ns);
        chk("wr_latency", tp - tr, 4);
        chk("wr_strobe_cycles", ns, 2);
        chk("wr_addr", saddr[0], 12'hFFF);
        chk("wr_din", sdin[0], 8'h81);
        chk("wr_rdata_untouched", rdata[0], 8'h3C);
        do_req(0, 1, 1'b0, 12'hFFF, 8'h00, tr, tp, ns);
        chk("wr_readback", rdata[0], 8'h81);

        // Contention: both requesters held valid for six operations.
        @(negedge clk);
        set_req(0, 0, 1'b1, 1'b0, 12'h0A5, 8'h00);
        set_req(0, 1, 1'b1, 1'b0, 12'h010, 8'h00);
        gcnt = 0; gseq = 6'b000000; prev = -1;
        for (int i = 0; i < 120 && gcnt < 6; i++) begin
            @(negedge clk);
            if (rdy0[0] || rdy1[0]) begin
                gseq[gcnt] = rdy1[0];
                if (prev >= 0) chk("rr_issue_interval", cyc - prev, 5);
                prev = cyc;
                gcnt++;
            end
        end
        set_req(0, 0, 1'b0, 1'b0, 12'h000, 8'h00);
        set_req(0, 1, 1'b0, 1'b0, 12'h000, 8'h00);
        chk("rr_grant_count", gcnt, 6);
        chk("rr_grant_order", gseq, 6'b101010);
        repeat (8) @(negedge clk);

        // Parameter sweep instance: RD_CYCLES=1, WR_CYCLES=5.
        do_req(1, 0, 1'b0, 12'h0A5, 8'h00, tr, tp, ns);
        chk("sw_rd_latency", tp - tr, 3);
        chk("sw_rd_cycles", ns, 1);
        chk("sw_rd_data", rdata[1], 8'h3C);
        do_req(1, 1, 1'b1, 12'h123, 8'hE7, tr, tp, ns);
        chk("sw_wr_latency", tp - tr, 7);
        chk("sw_wr_cycles", ns, 5);
        do_req(1, 0, 1'b0, 12'h123, 8'h00, tr, tp, ns);
        chk("sw_readback", rdata[1], 8'hE7);

        // Reset pulled during the second write cycle.
        @(negedge clk);
        set_req(0, 1, 1'b1, 1'b1, 12'h300, 8'h55);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = rdy1[0];
        end
        set_req(0, 1, 1'b0, 1'b0, 12'h000, 8'h00);
        chk("rst_mid_ready_seen", got, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_mid_wen_before", wen[0], 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_wen", wen[0], 1'b0);
        chk("rst_mid_busy", busy[0], 1'b0);
        chk("rst_mid_addr", saddr[0], 12'h000);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", rsp0[0] | rsp1[0], 1'b0);
        end

        // Recovery after reset.
        do_req(0, 0, 1'b0, 12'h0A5, 8'h00, tr, tp, ns);
        chk("post_rst_latency", tp - tr, 4);
        chk("post_rst_data", rdata[0], 8'h3C);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
